// File: rtl/exe_mem_skid_reg_if.sv
// exe_mem_skid_reg_if: valid/ready handshake carrying one EXE->MEM pipeline entry
interface exe_mem_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] store_data;
  logic [ADDR_W-1:0] branch_addr;
  logic [REG_W-1:0]  dst_reg;
  logic              zero;
  logic [CTRL_W-1:0] ctrl;
  modport master (output valid, result, store_data, branch_addr, dst_reg, zero, ctrl, input ready);
  modport slave  (input valid, result, store_data, branch_addr, dst_reg, zero, ctrl, output ready);
endinterface

// File: rtl/exe_mem_skid_reg.sv
// exe_mem_skid_reg: EXE->MEM pipeline register with a two-entry skid buffer and flush
module exe_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  exe_mem_skid_reg_if.slave   in_bus,
  exe_mem_skid_reg_if.master  out_bus,
  output logic                out_branch_taken
);
  localparam int W = 2 * DATA_W + ADDR_W + REG_W + 1 + CTRL_W;
  logic [W-1:0]      h, s, d;
  logic              h_valid, s_valid, in_fire, out_fire, h_zero;
  logic [CTRL_W-1:0] h_ctrl;
  assign d = {in_bus.result, in_bus.store_data, in_bus.branch_addr, in_bus.dst_reg, in_bus.zero, in_bus.ctrl};
  assign {out_bus.result, out_bus.store_data, out_bus.branch_addr, out_bus.dst_reg, h_zero, h_ctrl} = h;
  // in_ready comes straight from the skid flop so it never sees out_ready combinationally
  assign in_bus.ready = ~s_valid;
  assign in_fire  = in_bus.valid & ~s_valid;
  assign out_fire = h_valid & out_bus.ready;
  assign out_bus.valid = h_valid;
  assign out_bus.zero  = h_zero;
  // control write-enables of an empty or squashed head must not reach MEM
  assign out_bus.ctrl  = h_valid ? h_ctrl : '0;
  assign out_branch_taken = h_valid & ((h_ctrl[4] & h_zero) | (h_ctrl[5] & ~h_zero));
  // head/skid update: flush beats everything, skid refills head before new input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
      h       <= '0;
      s       <= '0;
    end else if (flush) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!h_valid) begin
      if (in_fire) begin
        h       <= d;
        h_valid <= 1'b1;
      end
    end else if (out_fire) begin
      if (s_valid) begin
        h       <= s;
        s_valid <= 1'b0;
      end else if (in_fire) begin
        h <= d;
      end else begin
        h_valid <= 1'b0;
      end
    end else if (in_fire) begin
      s       <= d;
      s_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// tb_exe_mem_skid_reg: FIFO-model scoreboard plus directed literal checks for the skid register
module tb_exe_mem_skid_reg;
  logic clk = 1'b0;
  logic rst_n, flush;
  logic br, br2;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  exe_mem_skid_reg_if in_bus ();
  exe_mem_skid_reg_if out_bus ();
  exe_mem_skid_reg_if #(.DATA_W(64), .CTRL_W(10)) in2 ();
  exe_mem_skid_reg_if #(.DATA_W(64), .CTRL_W(10)) out2 ();

  exe_mem_skid_reg dut (.clk(clk), .rst_n(rst_n), .flush(flush), .in_bus(in_bus), .out_bus(out_bus), .out_branch_taken(br));
  exe_mem_skid_reg #(.DATA_W(64), .CTRL_W(10)) dut2 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_bus(in2), .out_bus(out2), .out_branch_taken(br2));

  typedef struct {
    logic [31:0] result, store_data, branch_addr;
    logic [4:0]  dst;
    logic        zero;
    logic [7:0]  ctrl;
  } ent_t;
  ent_t q[$];
  bit m_in_fire, m_out_fire;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a FIFO holding at most two entries; flush empties it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else begin
      m_in_fire  = in_bus.valid && q.size() < 2;
      m_out_fire = q.size() > 0 && out_bus.ready;
      if (flush) q.delete();
      else begin
        if (m_out_fire) void'(q.pop_front());
        if (m_in_fire) q.push_back('{in_bus.result, in_bus.store_data, in_bus.branch_addr, in_bus.dst_reg, in_bus.zero, in_bus.ctrl});
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    chk("out_valid", 64'(out_bus.valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_bus.ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("result", 64'(out_bus.result), 64'(q[0].result));
      chk("store_data", 64'(out_bus.store_data), 64'(q[0].store_data));
      chk("branch_addr", 64'(out_bus.branch_addr), 64'(q[0].branch_addr));
      chk("dst_reg", 64'(out_bus.dst_reg), 64'(q[0].dst));
      chk("zero", 64'(out_bus.zero), 64'(q[0].zero));
      chk("ctrl", 64'(out_bus.ctrl), 64'(q[0].ctrl));
      chk("branch_taken", 64'(br), 64'((q[0].ctrl[4] && q[0].zero) || (q[0].ctrl[5] && !q[0].zero)));
    end else begin
      chk("ctrl_idle", 64'(out_bus.ctrl), 64'(0));
      chk("branch_idle", 64'(br), 64'(0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] r, input logic [7:0] c, input logic z);
    in_bus.valid       = 1'b1;
    in_bus.result      = r;
    in_bus.store_data  = ~r;
    in_bus.branch_addr = r << 2;
    in_bus.dst_reg     = r[4:0];
    in_bus.zero        = z;
    in_bus.ctrl        = c;
  endtask

  initial begin
    rst_n = 1'b1;
    flush = 1'b0;
    in_bus.valid = 1'b0;
    in_bus.result = '0;
    in_bus.store_data = '0;
    in_bus.branch_addr = '0;
    in_bus.dst_reg = '0;
    in_bus.zero = 1'b0;
    in_bus.ctrl = '0;
    out_bus.ready = 1'b0;
    in2.valid = 1'b0;
    in2.result = '0;
    in2.store_data = '0;
    in2.branch_addr = '0;
    in2.dst_reg = '0;
    in2.zero = 1'b0;
    in2.ctrl = '0;
    out2.ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_bus.valid), 64'(0));
    chk("rst_out_ctrl", 64'(out_bus.ctrl), 64'(0));
    chk("rst_in_ready", 64'(in_bus.ready), 64'(1));
    chk("rst_branch", 64'(br), 64'(0));
    chk("rst_result", 64'(out_bus.result), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    step();
    // streaming
    out_bus.ready = 1'b1;
    offer(32'h11, 8'h01, 1'b0); step();
    chk("stream_11", 64'(out_bus.result), 64'h11);
    offer(32'h22, 8'h03, 1'b0); step();
    chk("stream_22", 64'(out_bus.result), 64'h22);
    offer(32'h33, 8'h05, 1'b1); step();
    chk("stream_33", 64'(out_bus.result), 64'h33);
    chk("stream_ready", 64'(in_bus.ready), 64'(1));
    offer(32'h44, 8'h09, 1'b0); step();
    chk("stream_44", 64'(out_bus.result), 64'h44);
    chk("stream_ctrl44", 64'(out_bus.ctrl), 64'h09);
    in_bus.valid = 1'b0; step();
    chk("stream_empty", 64'(out_bus.valid), 64'(0));
    // stall and skid
    out_bus.ready = 1'b0;
    offer(32'h11, 8'h01, 1'b0); step();
    offer(32'h22, 8'h02, 1'b0); step();
    chk("skid_full_ready", 64'(in_bus.ready), 64'(0));
    chk("skid_head", 64'(out_bus.result), 64'h11);
    offer(32'h33, 8'h04, 1'b0); step();
    chk("skid_hold", 64'(out_bus.result), 64'h11);
    in_bus.valid = 1'b0;
    out_bus.ready = 1'b1; step();
    chk("skid_second", 64'(out_bus.result), 64'h22);
    chk("skid_ready_back", 64'(in_bus.ready), 64'(1));
    step();
    chk("skid_drained", 64'(out_bus.valid), 64'(0));
    // flush with both entries held and input offered
    out_bus.ready = 1'b0;
    offer(32'h55, 8'h01, 1'b0); step();
    offer(32'h66, 8'h02, 1'b0); step();
    offer(32'h99, 8'h0F, 1'b0);
    flush = 1'b1; step();
    flush = 1'b0;
    in_bus.valid = 1'b0;
    chk("flush_valid", 64'(out_bus.valid), 64'(0));
    chk("flush_ctrl", 64'(out_bus.ctrl), 64'(0));
    chk("flush_ready", 64'(in_bus.ready), 64'(1));
    out_bus.ready = 1'b1; step();
    chk("flush_gone", 64'(out_bus.valid), 64'(0));
    // branch resolution
    offer(32'hA0, 8'h10, 1'b1); step();
    chk("br_eq_taken", 64'(br), 64'(1));
    offer(32'hA1, 8'h20, 1'b1); step();
    chk("br_ne_not", 64'(br), 64'(0));
    offer(32'hA2, 8'h20, 1'b0); step();
    chk("br_ne_taken", 64'(br), 64'(1));
    in_bus.valid = 1'b0; step();
    chk("br_idle", 64'(br), 64'(0));
    // mixed handshake patterns, including flush while draining
    for (int i = 0; i < 48; i++) begin
      offer(32'h1000 + 32'(i), 8'(i * 37), 1'(i % 2));
      in_bus.valid  = (i % 3) != 2;
      out_bus.ready = (i % 5) != 1 && (i % 7) != 3;
      flush = (i == 20) || (i == 33);
      step();
    end
    flush = 1'b0;
    in_bus.valid = 1'b0;
    out_bus.ready = 1'b1;
    step();
    step();
    // async reset mid-stall
    out_bus.ready = 1'b0;
    offer(32'h71, 8'h11, 1'b1); step();
    offer(32'h72, 8'h12, 1'b1); step();
    in_bus.valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_bus.valid), 64'(0));
    chk("arst_ctrl", 64'(out_bus.ctrl), 64'(0));
    chk("arst_ready", 64'(in_bus.ready), 64'(1));
    chk("arst_branch", 64'(br), 64'(0));
    step();
    rst_n = 1'b1;
    out_bus.ready = 1'b1;
    step();
    // wide parameter instance
    in2.valid = 1'b1;
    in2.result = 64'hDEADBEEF_CAFEF00D;
    in2.store_data = 64'h0123456789ABCDEF;
    in2.ctrl = 10'h3C0;
    out2.ready = 1'b1;
    step();
    in2.valid = 1'b0;
    chk("wide_valid", 64'(out2.valid), 64'(1));
    chk("wide_result", out2.result, 64'hDEADBEEF_CAFEF00D);
    chk("wide_store", out2.store_data, 64'h0123456789ABCDEF);
    chk("wide_ctrl", 64'(out2.ctrl), 64'h3C0);
    chk("wide_branch", 64'(br2), 64'(0));
    step();
    chk("wide_drained", 64'(out2.valid), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
